// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low {a,b,c,d,e,f,g} hex font and blank pattern.
package seg7_pkg;

   localparam logic [6:0] SEG_0   = 7'b0000001;
   localparam logic [6:0] SEG_1   = 7'b1001111;
   localparam logic [6:0] SEG_2   = 7'b0010010;
   localparam logic [6:0] SEG_3   = 7'b0000110;
   localparam logic [6:0] SEG_4   = 7'b1001100;
   localparam logic [6:0] SEG_5   = 7'b0100100;
   localparam logic [6:0] SEG_6   = 7'b0100000;
   localparam logic [6:0] SEG_7   = 7'b0001111;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0000100;
   localparam logic [6:0] SEG_A   = 7'b0001000;
   localparam logic [6:0] SEG_B   = 7'b1100000;
   localparam logic [6:0] SEG_C   = 7'b0110001;
   localparam logic [6:0] SEG_D   = 7'b1000010;
   localparam logic [6:0] SEG_E   = 7'b0110000;
   localparam logic [6:0] SEG_F   = 7'b0111000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   typedef enum logic {
      BLINK_ON  = 1'b0,
      BLINK_OFF = 1'b1
   } blink_phase_e;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] pat;
      pat = SEG_OFF;
      case (nib)
         4'h0: pat = SEG_0;
         4'h1: pat = SEG_1;
         4'h2: pat = SEG_2;
         4'h3: pat = SEG_3;
         4'h4: pat = SEG_4;
         4'h5: pat = SEG_5;
         4'h6: pat = SEG_6;
         4'h7: pat = SEG_7;
         4'h8: pat = SEG_8;
         4'h9: pat = SEG_9;
         4'hA: pat = SEG_A;
         4'hB: pat = SEG_B;
         4'hC: pat = SEG_C;
         4'hD: pat = SEG_D;
         4'hE: pat = SEG_E;
         4'hF: pat = SEG_F;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = hex_font(nibble_i);
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered digits and PWM brightness.
// Optional digit blinking is enabled by defining SEG7_BLINK_EN.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned DIGIT_TICKS  = 100_000
`ifdef SEG7_BLINK_EN
   ,
   parameter int unsigned BLINK_FRAMES = 125
`endif
) (
   input  logic                    clk_100MHz,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [3:0]              brightness,
`ifdef SEG7_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit,
   output logic                    frame_done
);

   localparam int unsigned SUB_TICKS = DIGIT_TICKS / 16;
   localparam int unsigned SUBW      = $clog2(SUB_TICKS);
   localparam int unsigned SELW      = $clog2(NUM_DIGITS);
   localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SUB_TICKS - 1);
   localparam logic [SELW-1:0] SEL_LAST = SELW'(NUM_DIGITS - 1);

   // tick is kept as {phase, sub-count} so the phase needs no divider
   logic [SUBW-1:0]         sub_q, sub_d;
   logic [3:0]              phase_q, phase_d;
   logic [SELW-1:0]         sel_q, sel_d;
   logic                    slot_end, frame_end;

   logic [4*NUM_DIGITS-1:0] shadow_val_q, disp_val_q;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, disp_dp_q;

   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   digit_q, digit_d;

   logic [3:0]              nibble;
   logic                    dp_bit;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   digit_en;

   always_comb begin
      slot_end  = (phase_q == 4'hF) && (sub_q == SUB_LAST);
      frame_end = slot_end && (sel_q == SEL_LAST);
      sub_d     = sub_q + 1'b1;
      phase_d   = phase_q;
      sel_d     = sel_q;
      if (sub_q == SUB_LAST) begin
         sub_d   = '0;
         phase_d = phase_q + 4'd1;
      end
      if (slot_end) begin
         sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end
   end

   assign lit = (phase_q <= brightness);

`ifdef SEG7_BLINK_EN
   localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

   blink_phase_e   blink_q, blink_d;
   logic [BCW-1:0] blink_cnt_q, blink_cnt_d;

   always_comb begin
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q;
      if (frame_end) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_d     = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         blink_q     <= BLINK_ON;
         blink_cnt_q <= '0;
      end else begin
         blink_q     <= blink_d;
         blink_cnt_q <= blink_cnt_d;
      end
   end

   assign digit_en = {NUM_DIGITS{lit}} & ~(blink_mask & {NUM_DIGITS{blink_q == BLINK_OFF}});
`else
   assign digit_en = {NUM_DIGITS{lit}};
`endif

   always_comb begin
      nibble  = '0;
      dp_bit  = 1'b0;
      digit_d = '1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (sel_q == SELW'(i)) begin
            nibble     = disp_val_q[4*i +: 4];
            dp_bit     = disp_dp_q[i];
            digit_d[i] = ~digit_en[i];
         end
      end
      dp_d = ~dp_bit;
   end

   seg7_hex_decode u_hex_decode (
      .nibble_i (nibble),
      .seg_o    (seg_d)
   );

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         sub_q        <= '0;
         phase_q      <= '0;
         sel_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         seg_q        <= SEG_OFF;
         dp_q         <= 1'b1;
         digit_q      <= '1;
      end else begin
         sub_q   <= sub_d;
         phase_q <= phase_d;
         sel_q   <= sel_d;
         if (load) begin
            shadow_val_q <= value_in;
            shadow_dp_q  <= dp_in;
         end
         // Display takes the pre-load shadow when load and frame end coincide
         if (frame_end) begin
            disp_val_q <= shadow_val_q;
            disp_dp_q  <= shadow_dp_q;
         end
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         digit_q <= digit_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign digit      = digit_q;
   assign frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 32 ticks per slot); blink checks under SEG7_BLINK_EN.
module tb_seg7_scan_ctrl;

   logic        clk_100MHz;
   logic        reset;
   logic        load;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic [3:0]  brightness;
`ifdef SEG7_BLINK_EN
   logic [3:0]  blink_mask;
`endif
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  digit;
   logic        frame_done;

   int n_chk;
   int n_bad;

   seg7_scan_ctrl #(
      .NUM_DIGITS   (4),
      .DIGIT_TICKS  (32)
`ifdef SEG7_BLINK_EN
      ,
      .BLINK_FRAMES (2)
`endif
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .load       (load),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .brightness (brightness),
`ifdef SEG7_BLINK_EN
      .blink_mask (blink_mask),
`endif
      .seg        (seg),
      .dp         (dp),
      .digit      (digit),
      .frame_done (frame_done)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   // Returns on the negedge where frame_done is high; n = negedges waited
   task automatic wait_fd(input string tag, output int n);
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clk_100MHz);
         n = i;
         if (frame_done) break;
      end
      chk(tag, {31'd0, frame_done}, 32'd1);
   endtask

   initial begin
      int n;
      int cnt;
      logic [6:0] exp_seg [4];
      logic       exp_dp  [4];
      logic [3:0] exp_dig [4];
      string      nm;

      n_chk = 0;
      n_bad = 0;
      reset = 1'b1;
      load = 1'b0;
      value_in = '0;
      dp_in = '0;
      brightness = 4'd15;
`ifdef SEG7_BLINK_EN
      blink_mask = 4'b0000;
`endif

      // reset state and release
      repeat (3) @(negedge clk_100MHz);
      chk("rst_digit", {28'd0, digit}, 32'hF);
      chk("rst_seg", {25'd0, seg}, 32'h7F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
      reset = 1'b0;
      @(negedge clk_100MHz);
      chk("rel_digit", {28'd0, digit}, 32'hE);

      // load 1A08, dp on digit 1
      value_in = 16'h1A08;
      dp_in = 4'b0010;
      load = 1'b1;
      @(negedge clk_100MHz);
      load = 1'b0;
      chk("pre_xfer_seg", {25'd0, seg}, 32'h01);
      wait_fd("fd_a", n);
      @(negedge clk_100MHz);
      chk("fd_pulse", {31'd0, frame_done}, 32'd0);
      @(negedge clk_100MHz);
      exp_seg = '{7'b0000000, 7'b0000001, 7'b0001000, 7'b1001111};
      exp_dp  = '{1'b1, 1'b0, 1'b1, 1'b1};
      exp_dig = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      for (int k = 0; k < 4; k++) begin
         nm = $sformatf("slot%0d_seg", k);
         chk(nm, {25'd0, seg}, {25'd0, exp_seg[k]});
         nm = $sformatf("slot%0d_dp", k);
         chk(nm, {31'd0, dp}, {31'd0, exp_dp[k]});
         nm = $sformatf("slot%0d_digit", k);
         chk(nm, {28'd0, digit}, {28'd0, exp_dig[k]});
         repeat (32) @(negedge clk_100MHz);
      end

      // brightness duty
      brightness = 4'd3;
      wait_fd("fd_b3", n);
      repeat (2) @(negedge clk_100MHz);
      cnt = 0;
      for (int t = 0; t < 32; t++) begin
         if (digit == 4'b1110) cnt++;
         @(negedge clk_100MHz);
      end
      chk("duty_b3", cnt, 32'd8);
      brightness = 4'd0;
      wait_fd("fd_b0", n);
      repeat (2) @(negedge clk_100MHz);
      cnt = 0;
      for (int t = 0; t < 32; t++) begin
         if (digit == 4'b1110) cnt++;
         @(negedge clk_100MHz);
      end
      chk("duty_b0", cnt, 32'd2);
      brightness = 4'd15;

      // load coinciding with frame_done
      value_in = 16'h1111;
      dp_in = 4'b0000;
      load = 1'b1;
      @(negedge clk_100MHz);
      load = 1'b0;
      wait_fd("fd_c", n);
      value_in = 16'h2222;
      load = 1'b1;
      @(negedge clk_100MHz);
      load = 1'b0;
      @(negedge clk_100MHz);
      chk("coinc_first", {25'd0, seg}, 32'h4F);
      wait_fd("fd_d", n);
      repeat (2) @(negedge clk_100MHz);
      chk("coinc_next", {25'd0, seg}, 32'h12);

      // back-to-back loads: last one wins
      value_in = 16'h3333;
      load = 1'b1;
      @(negedge clk_100MHz);
      value_in = 16'h0004;
      @(negedge clk_100MHz);
      load = 1'b0;
      wait_fd("fd_e", n);
      repeat (2) @(negedge clk_100MHz);
      chk("b2b_last", {25'd0, seg}, 32'h4C);

      // asynchronous reset mid-frame at digit 2, tick 17
      wait_fd("fd_f", n);
      repeat (82) @(negedge clk_100MHz);
      chk("pre_rst_digit", {28'd0, digit}, 32'hB);
      #2 reset = 1'b1;
      #1;
      chk("arst_digit", {28'd0, digit}, 32'hF);
      chk("arst_seg", {25'd0, seg}, 32'h7F);
      chk("arst_dp", {31'd0, dp}, 32'd1);
      chk("arst_fd", {31'd0, frame_done}, 32'd0);
      repeat (2) @(negedge clk_100MHz);
      reset = 1'b0;
      @(negedge clk_100MHz);
      chk("rerel_digit", {28'd0, digit}, 32'hE);
      chk("rerel_seg", {25'd0, seg}, 32'h01);
      wait_fd("fd_g", n);
      chk("rerel_fd_dist", n, 32'd126);

`ifdef SEG7_BLINK_EN
      blink_mask = 4'b0100;
      reset = 1'b1;
      @(negedge clk_100MHz);
      reset = 1'b0;
      for (int f = 0; f < 6; f++) begin
         repeat (33) @(negedge clk_100MHz);
         nm = $sformatf("blink_f%0d_d1", f);
         chk(nm, {28'd0, digit}, 32'hD);
         repeat (32) @(negedge clk_100MHz);
         nm = $sformatf("blink_f%0d_d2", f);
         chk(nm, {28'd0, digit}, (f == 2 || f == 3) ? 32'hF : 32'hB);
         repeat (63) @(negedge clk_100MHz);
      end
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of multiplexed digits (2..16).
REQ-002 SHALL have parameter DIGIT_TICKS, default 100_000, clk_100MHz cycles each digit is selected; a multiple of 16, at least 32.
REQ-003 SHALL have port clk_100MHz  input  1  system clock, 100 MHz.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load  input  1  single-cycle strobe capturing value_in and dp_in into the shadow registers.
REQ-006 SHALL have port value_in  input  4*NUM_DIGITS  hex nibbles; nibble i [4i+3:4i] drives digit i, digit 0 rightmost.
REQ-007 SHALL have port dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-008 SHALL have port brightness  input  4  duty level 0..15, sampled continuously.
REQ-009 SHALL have port seg  output  7  active-low segments {a,b,c,d,e,f,g}, registered.
REQ-010 SHALL have port dp  output  1  active-low decimal point, registered.
REQ-011 SHALL have port digit  output  NUM_DIGITS  active-low anode enables, registered, at most one low.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on the last cycle of the last digit slot.

Function
REQ-013 SHALL count tick 0..DIGIT_TICKS-1; at DIGIT_TICKS-1 tick wraps to 0 and digit_sel advances 0,1,..,NUM_DIGITS-1, then wraps to 0.
REQ-014 SHALL derive a 4-bit phase = tick / (DIGIT_TICKS/16), so each slot has 16 equal sub-slots.
REQ-015 SHALL drive digit[digit_sel] low only while phase <= brightness; brightness 15 = full on, 0 = 1/16 duty; all other anodes high.
REQ-016 SHALL decode the displayed nibble with the team's 16-pattern hex font, e.g. 0 = 0000001, 1 = 1001111, 8 = 0000000, F = 0111000.
REQ-017 SHALL register seg, dp and digit one cycle after digit_sel/phase change (latency 1 clock).
REQ-018 SHALL double-buffer: load writes the shadow; shadow copies to the display register only on the frame_done cycle, so no frame shows mixed data.
REQ-019 SHALL, when load and frame_done coincide, transfer the pre-load shadow; the newly loaded data appears one frame later.
REQ-020 SHALL, on back-to-back loads within a frame, display only the last loaded value.
REQ-021 SHALL assert frame_done when digit_sel = NUM_DIGITS-1 and tick = DIGIT_TICKS-1.

Reset
REQ-022 SHALL, on reset, set tick, digit_sel, shadow and display registers to 0, digit all 1s, seg 1111111, dp 1 and frame_done 0, immediately and regardless of clock.
REQ-023 SHALL, after reset deasserts mid-frame, restart scanning at digit 0, tick 0, on the next clock.

Configuration
REQ-024 SHALL support macro SEG7_BLINK_EN; when defined, it adds input blink_mask [NUM_DIGITS] and parameter BLINK_FRAMES (default 125), and toggles a blink phase every BLINK_FRAMES frame_done pulses.
REQ-025 SHALL, with SEG7_BLINK_EN defined, hold the anode high for digit i while the blink phase is off and blink_mask[i] = 1; the blink phase resets to on.
REQ-026 SHALL, without SEG7_BLINK_EN, omit blink_mask and all blink logic; behaviour is otherwise identical.

Structure
REQ-027 SHALL place the 16 segment-pattern constants, SEG_OFF = 1111111, and the font lookup function in shared package seg7_pkg.
REQ-028 SHALL instantiate combinational sub-module seg7_hex_decode (4-bit nibble in, 7-bit active-low pattern out) once, on the muxed nibble.

Verification (NUM_DIGITS=4, DIGIT_TICKS=32 unless noted)
REQ-029 SHALL cover: assert reset -> digit=1111, seg=1111111, dp=1; release reset -> digit=1110 one clock later.
REQ-030 SHALL cover: load value_in=16'h1A08, dp_in=4'b0010, brightness=15 -> after the next frame_done, successive slots show 0000000 (8), 0000001 with dp=0 (0), 0001000 (A), 1001111 (1).
REQ-031 SHALL cover: brightness=3 -> anode low for exactly 8 of 32 cycles per slot; brightness=0 -> exactly 2 cycles.
REQ-032 SHALL cover: load 16'h1111 then, on the frame_done cycle, load 16'h2222 -> the next frame shows 1111 and the frame after shows 2222.
REQ-033 SHALL cover: reset pulse while digit_sel=2, tick=17 -> outputs go to reset values immediately; scanning resumes at digit 0.
REQ-034 SHALL cover, under SEG7_BLINK_EN with BLINK_FRAMES=2 and blink_mask=4'b0100: digit 2 is dark in frames 2-3, lit in frames 0-1 and 4-5, and other digits are unaffected.
